// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: round-robin ownership of one SRAM port with tagged, latency-matched read-data return
module sram_port_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int READ_LAT = 2
) (
   input  logic                    CLOCK_50_I,
   input  logic                    Resetn,
   input  logic [NUM_REQ-1:0]      req,
   input  logic [18*NUM_REQ-1:0]   req_address,
   input  logic [16*NUM_REQ-1:0]   req_write_data,
   input  logic [NUM_REQ-1:0]      req_we_n,
   output logic [NUM_REQ-1:0]      gnt,
   output logic [15:0]             rd_data,
   output logic [NUM_REQ-1:0]      rd_valid,
   output logic                    busy,
   output logic [17:0]             SRAM_address,
   output logic [15:0]             SRAM_write_data,
   output logic                    SRAM_we_n,
   input  logic [15:0]             SRAM_read_data
);
   localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   typedef enum logic {S_ARB_IDLE, S_ARB_OWN} state_t;
   state_t              state_q, state_d;
   logic [OW-1:0]       owner_q, owner_d, last_owner_q, last_owner_d, win, idx;
   logic                found, access;
   logic [NUM_REQ-1:0]  gnt_q, gnt_d, rd_valid_q, rd_valid_d;
   logic [17:0]         addr_q, addr_d;
   logic [15:0]         wdata_q, wdata_d;
   logic                we_n_q, we_n_d;
   logic [READ_LAT-1:0] tag_v_q, tag_v_d;
   logic [OW-1:0]       tag_id_q [READ_LAT];
   logic [OW-1:0]       tag_id_d [READ_LAT];
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = OW'((int'(last_owner_q) + k) % NUM_REQ);
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end
   assign access = (state_q == S_ARB_OWN) && req[owner_q];
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      gnt_d        = gnt_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      we_n_d       = 1'b1;
      if (state_q == S_ARB_IDLE) begin
         if (found) begin
            state_d      = S_ARB_OWN;
            owner_d      = win;
            last_owner_d = win;
            gnt_d        = NUM_REQ'(1) << win;
         end
      end else if (access) begin
         addr_d  = req_address[int'(owner_q)*18 +: 18];
         wdata_d = req_write_data[int'(owner_q)*16 +: 16];
         we_n_d  = req_we_n[owner_q];
      end else begin
         gnt_d   = '0;
         state_d = S_ARB_IDLE;
      end
      // each captured access enters the tag pipe; only reads carry a valid tag
      tag_v_d[0]  = access && req_we_n[owner_q];
      tag_id_d[0] = owner_q;
      for (int i = 1; i < READ_LAT; i++) begin
         tag_v_d[i]  = tag_v_q[i-1];
         tag_id_d[i] = tag_id_q[i-1];
      end
      rd_valid_d = tag_v_q[READ_LAT-1] ? NUM_REQ'(1) << tag_id_q[READ_LAT-1] : '0;
   end
   always_ff @(posedge CLOCK_50_I) begin
      if (!Resetn) begin
         state_q      <= S_ARB_IDLE;
         owner_q      <= '0;
         last_owner_q <= OW'(NUM_REQ - 1);
         gnt_q        <= '0;
         rd_valid_q   <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         we_n_q       <= 1'b1;
         tag_v_q      <= '0;
         tag_id_q     <= '{default: '0};
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         gnt_q        <= gnt_d;
         rd_valid_q   <= rd_valid_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         we_n_q       <= we_n_d;
         tag_v_q      <= tag_v_d;
         tag_id_q     <= tag_id_d;
      end
   end
   assign gnt             = gnt_q;
   assign rd_valid        = rd_valid_q;
   assign rd_data         = SRAM_read_data;
   assign busy            = (state_q == S_ARB_OWN);
   assign SRAM_address    = addr_q;
   assign SRAM_write_data = wdata_q;
   assign SRAM_we_n       = we_n_q;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed cycle checks plus a read-return scoreboard against an SRAM model
module tb_sram_port_arbiter;
   localparam int N = 4, LAT = 2;
   logic          clk = 1'b0;
   logic          resetn;
   logic [N-1:0]  req, req_we_n, gnt, rd_valid;
   logic [18*N-1:0] req_address;
   logic [16*N-1:0] req_write_data;
   logic [15:0]   rd_data, sram_wd, sram_rd;
   logic [17:0]   sram_addr;
   logic          busy, sram_we_n;
   logic [17:0]   apipe [LAT];
   typedef struct {int id; logic [15:0] d;} exp_t;
   exp_t sb[$];
   exp_t e_m;
   int n_err = 0, n_chk = 0;

   sram_port_arbiter #(.NUM_REQ(N), .READ_LAT(LAT)) dut (
      .CLOCK_50_I(clk), .Resetn(resetn), .req(req), .req_address(req_address),
      .req_write_data(req_write_data), .req_we_n(req_we_n), .gnt(gnt), .rd_data(rd_data),
      .rd_valid(rd_valid), .busy(busy), .SRAM_address(sram_addr), .SRAM_write_data(sram_wd),
      .SRAM_we_n(sram_we_n), .SRAM_read_data(sram_rd));

   always #5 clk = ~clk;

   function automatic logic [15:0] rdat(input logic [17:0] a);
      return (a == 18'd38400) ? 16'hA5C3 : (a[15:0] ^ 16'h5A5A);
   endfunction

   // SRAM model: data for the address presented LAT cycles ago
   always @(posedge clk) begin
      apipe[0] <= sram_addr;
      for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
   end
   assign sram_rd = rdat(apipe[LAT-1]);

   always @(negedge clk) begin
      if (|rd_valid === 1'b1) begin
         n_chk++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL sb_unexpected rd_valid=%b rd_data=%h expected no return", rd_valid, rd_data);
         end else begin
            e_m = sb.pop_front();
            if (rd_valid !== (4'b1 << e_m.id) || rd_data !== e_m.d) begin
               n_err++;
               $display("FAIL sb_return rd_valid=%b rd_data=%h expected rd_valid=%b rd_data=%h",
                        rd_valid, rd_data, 4'b1 << e_m.id, e_m.d);
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic set_r(input int i, input logic r, input logic [17:0] a, input logic w, input logic [15:0] d);
      req[i] = r;
      req_address[i*18 +: 18] = a;
      req_we_n[i] = w;
      req_write_data[i*16 +: 16] = d;
   endtask

   task automatic push_exp(input int i, input logic [17:0] a);
      exp_t e;
      e.id = i;
      e.d  = rdat(a);
      sb.push_back(e);
   endtask

   task automatic own(input int i);
      repeat (3) begin
         chk("rr_gnt", 32'(gnt), 32'(4'b1 << i));
         cyc();
      end
      chk("rr_gnt_release", 32'(gnt), 32'(4'b1 << i));
      req[i] = 1'b0;
      cyc();
      chk("rr_gap", 32'(gnt), 32'h0);
      cyc();
   endtask

   initial begin
      resetn = 1'b0;
      req = '1;
      req_address = '0;
      req_write_data = '0;
      req_we_n = '1;
      repeat (3) begin
         cyc();
         chk("rst_gnt", 32'(gnt), 32'h0);
         chk("rst_we_n", 32'(sram_we_n), 32'h1);
         chk("rst_addr", 32'(sram_addr), 32'h0);
         chk("rst_wdata", 32'(sram_wd), 32'h0);
         chk("rst_rd_valid", 32'(rd_valid), 32'h0);
         chk("rst_busy", 32'(busy), 32'h0);
      end
      req = '0;
      resetn = 1'b1;
      cyc();
      // single read by requester 1
      set_r(1, 1'b1, 18'd38400, 1'b1, 16'h0);
      cyc();
      chk("rd_gnt", 32'(gnt), 32'h2);
      chk("rd_busy", 32'(busy), 32'h1);
      push_exp(1, 18'd38400);
      cyc();
      chk("rd_addr", 32'(sram_addr), 32'd38400);
      chk("rd_we_n", 32'(sram_we_n), 32'h1);
      req[1] = 1'b0;
      cyc();
      chk("rd_release_gnt", 32'(gnt), 32'h0);
      chk("rd_early_valid", 32'(rd_valid), 32'h0);
      cyc();
      chk("rd_valid", 32'(rd_valid), 32'h2);
      chk("rd_data", 32'(rd_data), 32'hA5C3);
      cyc();
      chk("rd_valid_pulse", 32'(rd_valid), 32'h0);
      // write plus priority right after reset
      resetn = 1'b0;
      cyc();
      resetn = 1'b1;
      cyc();
      set_r(0, 1'b1, 18'd146944, 1'b0, 16'h1234);
      set_r(2, 1'b1, 18'd5, 1'b0, 16'hBEEF);
      cyc();
      chk("wr_gnt", 32'(gnt), 32'h1);
      cyc();
      chk("wr_we_n", 32'(sram_we_n), 32'h0);
      chk("wr_addr", 32'(sram_addr), 32'd146944);
      chk("wr_wdata", 32'(sram_wd), 32'h1234);
      repeat (3) cyc();
      req[0] = 1'b0;
      cyc();
      chk("wr_gap_gnt", 32'(gnt), 32'h0);
      chk("wr_gap_busy", 32'(busy), 32'h0);
      chk("wr_gap_we_n", 32'(sram_we_n), 32'h1);
      chk("wr_gap_addr_hold", 32'(sram_addr), 32'd146944);
      cyc();
      chk("wr_next_gnt", 32'(gnt), 32'h4);
      cyc();
      chk("wr2_addr", 32'(sram_addr), 32'd5);
      chk("wr2_wdata", 32'(sram_wd), 32'hBEEF);
      chk("wr2_we_n", 32'(sram_we_n), 32'h0);
      req[2] = 1'b0;
      cyc();
      chk("wr2_release", 32'(gnt), 32'h0);
      cyc();
      // round-robin from last_owner=2
      set_r(3, 1'b1, 18'd100, 1'b0, 16'h3333);
      set_r(0, 1'b1, 18'd200, 1'b0, 16'h0000);
      set_r(1, 1'b1, 18'd300, 1'b0, 16'h1111);
      cyc();
      own(3);
      own(0);
      own(1);
      // handoff with reads in flight
      set_r(0, 1'b1, 18'd0, 1'b1, 16'h0);
      cyc();
      chk("ho_gnt0", 32'(gnt), 32'h1);
      push_exp(0, 18'd0);
      set_r(2, 1'b1, 18'd7, 1'b0, 16'h7777);
      cyc();
      chk("ho_addr0", 32'(sram_addr), 32'd0);
      set_r(0, 1'b1, 18'd1, 1'b1, 16'h0);
      push_exp(0, 18'd1);
      cyc();
      chk("ho_addr1", 32'(sram_addr), 32'd1);
      req[0] = 1'b0;
      cyc();
      chk("ho_idle_gnt", 32'(gnt), 32'h0);
      chk("ho_rv0", 32'(rd_valid), 32'h1);
      chk("ho_rd0", 32'(rd_data), 32'h5A5A);
      cyc();
      chk("ho_gnt2", 32'(gnt), 32'h4);
      chk("ho_rv1", 32'(rd_valid), 32'h1);
      chk("ho_rd1", 32'(rd_data), 32'h5A5B);
      cyc();
      chk("ho_rv_done", 32'(rd_valid), 32'h0);
      req[2] = 1'b0;
      cyc();
      chk("ho_release", 32'(gnt), 32'h0);
      cyc();
      // reset with two reads in flight
      set_r(0, 1'b1, 18'd10, 1'b1, 16'h0);
      cyc();
      chk("mr_gnt", 32'(gnt), 32'h1);
      set_r(0, 1'b1, 18'd11, 1'b1, 16'h0);
      cyc();
      resetn = 1'b0;
      req = '0;
      cyc();
      resetn = 1'b1;
      repeat (3) begin
         chk("mr_gnt_clear", 32'(gnt), 32'h0);
         chk("mr_busy", 32'(busy), 32'h0);
         chk("mr_rd_valid", 32'(rd_valid), 32'h0);
         cyc();
      end
      set_r(0, 1'b1, 18'd20, 1'b0, 16'h0001);
      set_r(3, 1'b1, 18'd30, 1'b0, 16'h0003);
      cyc();
      chk("mr_prio0", 32'(gnt), 32'h1);
      req = '0;
      cyc();
      chk("mr_release", 32'(gnt), 32'h0);
      set_r(3, 1'b1, 18'd30, 1'b0, 16'h0003);
      cyc();
      chk("mr_sole3", 32'(gnt), 32'h8);
      req = '0;
      repeat (6) cyc();
      chk("sb_drain", 32'(sb.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares the single external SRAM port (18-bit address, 16-bit data, active-low write enable) between up to NUM_REQ requesters: UART loader, Milestone 1 upsampler/CSC, Milestone 2, and the VGA reader.
- Grants ownership to one requester at a time and holds it until that requester releases its request.
- Registers the owner's access onto the SRAM pins and routes returning read data to the requester that issued the read, using a latency-matched tag pipeline.

Parameters:
NUM_REQ, 4, number of requesters; requester i uses slice i of every packed bus.
READ_LAT, 2, cycles from SRAM_address presentation to valid SRAM_read_data; legal range 1..4.

Ports:
CLOCK_50_I  in  1  system clock, 50 MHz; all logic on rising edge.
Resetn  in  1  synchronous, active-low reset.
req  in  NUM_REQ  request or hold ownership, one bit per requester.
req_address  in  18*NUM_REQ  requester i address at [18i+17:18i].
req_write_data  in  16*NUM_REQ  requester i write data at [16i+15:16i].
req_we_n  in  NUM_REQ  requester i write enable, active low; 1 = read.
gnt  out  NUM_REQ  one-hot or zero; registered.
rd_data  out  16  broadcast read data; combinational copy of SRAM_read_data.
rd_valid  out  NUM_REQ  one-hot or zero; pulses in the cycle rd_data belongs to requester i.
busy  out  1  high while in S_ARB_OWN.
SRAM_address  out  18  registered.
SRAM_write_data  out  16  registered.
SRAM_we_n  out  1  registered.
SRAM_read_data  in  16  from SRAM controller.

Behaviour:
- Reset, sampled on the clock edge while Resetn=0:
  - Outputs: gnt=0, rd_valid=0, busy=0, SRAM_we_n=1, SRAM_address=0, SRAM_write_data=0.
  - Internal: state=S_ARB_IDLE, last_owner=NUM_REQ-1, all tag-pipeline entries invalid.
  - Reset mid-operation drops all in-flight reads: no rd_valid pulse is ever produced for them.
- States: S_ARB_IDLE, S_ARB_OWN.
- S_ARB_IDLE:
  - SRAM_we_n<=1; address and write data hold.
  - If any req bit is set: pick the first set bit scanning round-robin from (last_owner+1) mod NUM_REQ, upward with wrap.
  - Then gnt<=onehot(winner), owner<=winner, last_owner<=winner, state<=S_ARB_OWN. Otherwise stay.
- S_ARB_OWN with req[owner]=1:
  - SRAM_address<=req_address[owner], SRAM_write_data<=req_write_data[owner], SRAM_we_n<=req_we_n[owner].
  - Every gnt cycle with req held is exactly one access. Requester FSMs hold req for the whole transaction, i.e. a full M1 line.
- S_ARB_OWN with req[owner]=0 (release):
  - That cycle's inputs are ignored; SRAM_we_n<=1; gnt<=0; state<=S_ARB_IDLE.
  - A release always produces one idle turnaround cycle before the next grant. There is no preemption.
- Requesters without gnt: their inputs never reach the SRAM pins. Requests arriving during S_ARB_OWN wait.
- Cycle timing for a request raised in cycle c while idle:
  - gnt visible in c+1.
  - The access driven in c+1 appears on the SRAM pins in c+2.
  - For a read, rd_valid[owner]=1 in cycle c+2+READ_LAT, with rd_data equal to SRAM_read_data in that cycle.
- Tag pipeline:
  - READ_LAT-deep shift of {valid, id}, pushed on every captured access with valid = read.
  - Writes and idle cycles push invalid entries.
  - Reads in flight at a release or handoff still return to their issuer, even after gnt has moved.
- Back-to-back reads at one access per cycle produce one rd_valid per cycle, in issue order.
- Simultaneous release by the owner and new requests: release wins that cycle; arbitration happens in the following S_ARB_IDLE cycle.
- A req bit beyond the owner changing while owned has no effect.
- Width rules: no arithmetic on data. owner and last_owner are ceil(log2(NUM_REQ)) bits; the round-robin wrap is modulo NUM_REQ.

Test Plan:
- Reset: hold Resetn=0 for 3 cycles while req=4'b1111 -> gnt=0, SRAM_we_n=1, SRAM_address=0, SRAM_write_data=0, rd_valid=0, busy=0 throughout.
- Single read: req[1]=1 in cycle 0, address 38400, we_n=1; SRAM model returns 16'hA5C3 -> gnt=4'b0010 in cycle 1, SRAM_address=38400 in cycle 2, rd_valid=4'b0010 with rd_data=16'hA5C3 in cycle 4.
- Write plus priority: req=4'b0101 right after reset, requester 0 writes 16'h1234 to 146944 -> SRAM_we_n=0, SRAM_address=146944, SRAM_write_data=16'h1234 in cycle 2. req[0] drops in cycle 5 -> gnt=0 in cycle 6, gnt=4'b0100 in cycle 7.
- Round-robin: last_owner=2, req=4'b1011 held, each owner releasing after 3 accesses -> grant order 3, 0, 1, with exactly one idle cycle between grants.
- Handoff with in-flight reads: requester 0 reads addresses 0,1 in its last two gnt cycles, then releases while req[2] is high -> rd_valid[0] pulses twice with data from 0 and 1. rd_valid[2] is never set for those reads, even though gnt[2] is already asserted.
- Mid-burst reset: Resetn=0 for one cycle while 2 reads are in flight -> no rd_valid pulse afterwards; gnt=0 and state idle; next req[3] is granted before requester 0 only if it is the sole requester.
